// File: rtl/z80_intc_pkg.sv
// z80_intc_pkg: shared constants for the Z80 mode-2 interrupt controller.
// Holds register indices, ack FSM state encodings and the channel ceiling.
package z80_intc_pkg;
    localparam int MAX_CH = 8;
    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_MODE  = 2'd2;
    localparam logic [1:0] REG_VBASE = 2'd3;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;
endpackage

// File: rtl/z80_intc_if.sv
// z80_intc_if: CPU-side bus of the interrupt controller.
// master = CPU/decoder side (drives strobes, addr, din, reti);
// slave  = controller side (drives dout, vec, vec_oe, int_n).
interface z80_intc_if;
    logic       io_cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       m1_n;
    logic       iorq_n;
    logic       reti;
    logic [7:0] vec;
    logic       vec_oe;
    logic       int_n;
    modport master (output io_cs_n, rd_n, wr_n, addr, din, m1_n, iorq_n, reti,
                     input  dout, vec, vec_oe, int_n);
    modport slave  (input  io_cs_n, rd_n, wr_n, addr, din, m1_n, iorq_n, reti,
                     output dout, vec, vec_oe, int_n);
endinterface

// File: rtl/z80_intc_prio.sv
// z80_intc_prio: fixed-priority encoder, index 0 wins.
// Ports: elig_i (eligible channels), valid_o (any eligible), winner_o (lowest set index).
module z80_intc_prio
    import z80_intc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                 elig_i,
    output logic                         valid_o,
    output logic [$clog2(MAX_CH)-1:0]    winner_o
);
    always_comb begin
        winner_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (elig_i[i]) winner_o = ($clog2(MAX_CH))'(i);
    end
    assign valid_o = |elig_i;
endmodule

// File: rtl/z80_intc.sv
// z80_intc: Z80 mode-2 interrupt controller with mask, edge/level capture,
// fixed priority, in-service tracking until RETI and daisy-chain iei/ieo.
// Ports: clk_sys_i, reset_n_i (async active-low), irq_src_i[NUM_CH],
//        iei_i/ieo_o daisy chain, bus (z80_intc_if.slave: register port,
//        ack strobes, reti, vec/vec_oe, int_n).
// Define Z80_INTC_MODE_SEL_EN to enable the per-channel MODE (level) register;
// otherwise every channel is edge-triggered and MODE reads 0.
module z80_intc
    import z80_intc_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] VEC_RESET = 8'h08
) (
    input  logic              clk_sys_i,
    input  logic              reset_n_i,
    input  logic [NUM_CH-1:0] irq_src_i,
    input  logic              iei_i,
    output logic              ieo_o,
    z80_intc_if.slave         bus
);
    logic [NUM_CH-1:0] mask_q, pend_q, insv_q, prev_q;
    logic [NUM_CH-1:0] allow, elig, rise, clr_wr, onehot, pend_edge, pend_d, insv_d;
    logic [7:0]        vbase_q, vec_q, vec_d, mode_rd;
    logic [0:0]        state_q;
    logic              vec_oe_q, int_n_q, seen, valid, wr, ack, take;
    logic [$clog2(MAX_CH)-1:0] winner;

    // A channel may only interrupt if nothing of equal or higher priority is in service.
    always_comb begin
        seen  = 1'b0;
        allow = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            seen     = seen | insv_q[i];
            allow[i] = ~seen;
        end
    end

    assign elig = pend_q & ~mask_q & allow;

    z80_intc_prio #(.N(NUM_CH)) u_prio (
        .elig_i   (elig),
        .valid_o  (valid),
        .winner_o (winner)
    );

    assign wr        = ~bus.io_cs_n & ~bus.wr_n;
    assign ack       = ~bus.m1_n & ~bus.iorq_n;
    assign take      = (state_q == IDLE) && ack && iei_i && valid;
    assign onehot    = take ? (NUM_CH'(1) << winner) : '0;
    assign rise      = irq_src_i & ~prev_q;
    assign clr_wr    = (wr && bus.addr == REG_PEND) ? bus.din[NUM_CH-1:0] : '0;
    // New edges are ORed in last so they win over any clear in the same cycle.
    assign pend_edge = (pend_q & ~clr_wr & ~onehot) | rise;
    // Lowest set bit is the highest-priority service; x & (x-1) drops it.
    assign insv_d    = (bus.reti ? insv_q & (insv_q - NUM_CH'(1)) : insv_q) | onehot;
    assign vec_d     = vbase_q + 8'({winner, 1'b0});

`ifdef Z80_INTC_MODE_SEL_EN
    logic [NUM_CH-1:0] mode_q;
    assign pend_d  = (mode_q & irq_src_i) | (~mode_q & pend_edge);
    assign mode_rd = 8'(mode_q);
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i)                        mode_q <= '0;
        else if (wr && bus.addr == REG_MODE)   mode_q <= bus.din[NUM_CH-1:0];
    end
`else
    assign pend_d  = pend_edge;
    assign mode_rd = 8'h00;
`endif

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_q   <= '1;
            pend_q   <= '0;
            insv_q   <= '0;
            prev_q   <= '0;
            vbase_q  <= VEC_RESET;
            vec_q    <= 8'h00;
            state_q  <= IDLE;
            vec_oe_q <= 1'b0;
            int_n_q  <= 1'b1;
        end else begin
            prev_q  <= irq_src_i;
            pend_q  <= pend_d;
            insv_q  <= insv_d;
            int_n_q <= ~(iei_i & |elig);
            if (wr && bus.addr == REG_MASK)  mask_q  <= bus.din[NUM_CH-1:0];
            if (wr && bus.addr == REG_VBASE) vbase_q <= bus.din;
            if (take) vec_q <= vec_d;
            if (state_q == IDLE) begin
                if (ack) begin
                    state_q  <= ACK;
                    vec_oe_q <= take;
                end
            end else if (!ack) begin
                state_q  <= IDLE;
                vec_oe_q <= 1'b0;
            end
        end
    end

    assign bus.dout   = (~bus.io_cs_n & ~bus.rd_n) ?
                        (bus.addr == REG_MASK ? 8'(mask_q) :
                         bus.addr == REG_PEND ? 8'(pend_q) :
                         bus.addr == REG_MODE ? mode_rd : vbase_q) : 8'h00;
    assign bus.vec    = vec_q;
    assign bus.vec_oe = vec_oe_q;
    assign bus.int_n  = int_n_q;
    assign ieo_o      = iei_i & ~|insv_q & int_n_q;
endmodule

// File: tb/tb_z80_intc.sv
// tb_z80_intc: directed self-checking bench for z80_intc (NUM_CH=4, VEC_RESET=8'h08).
module tb_z80_intc;
    import z80_intc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq = '0;
    logic       iei = 1'b1;
    logic       ieo;
    logic [7:0] d;
    int         pass_cnt = 0;
    int         total = 0;

`ifdef Z80_INTC_MODE_SEL_EN
    localparam logic [7:0] EXP_MODE = 8'h01;
    localparam logic [7:0] EXP_LVL_PEND = 8'h01;
`else
    localparam logic [7:0] EXP_MODE = 8'h00;
    localparam logic [7:0] EXP_LVL_PEND = 8'h00;
`endif

    z80_intc_if bus ();

    z80_intc #(.NUM_CH(4), .VEC_RESET(8'h08)) dut (
        .clk_sys_i (clk),
        .reset_n_i (rst_n),
        .irq_src_i (irq),
        .iei_i     (iei),
        .ieo_o     (ieo),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
        bus.io_cs_n = 1'b0; bus.wr_n = 1'b0; bus.addr = a; bus.din = v;
        tick();
        bus.io_cs_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
        bus.io_cs_n = 1'b0; bus.rd_n = 1'b0; bus.addr = a;
        #1;
        v = bus.dout;
        bus.io_cs_n = 1'b1; bus.rd_n = 1'b1;
    endtask

    task automatic pulse(input int ch);
        irq[ch] = 1'b1;
        tick();
        irq[ch] = 1'b0;
    endtask

    task automatic ack_on();
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        tick();
    endtask

    task automatic ack_off();
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
        tick();
    endtask

    task automatic do_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    task automatic test_reset();
        bus.io_cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.addr = 2'd0; bus.din = 8'h00;
        bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.reti = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rd_reg(REG_MASK, d);
        total++; if (d !== 8'h0F) $display("FAIL reset_mask got %h want 0f", d); else pass_cnt++;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h00) $display("FAIL reset_pend got %h want 00", d); else pass_cnt++;
        rd_reg(REG_MODE, d);
        total++; if (d !== 8'h00) $display("FAIL reset_mode got %h want 00", d); else pass_cnt++;
        rd_reg(REG_VBASE, d);
        total++; if (d !== 8'h08) $display("FAIL reset_vbase got %h want 08", d); else pass_cnt++;
        total++; if (bus.int_n !== 1'b1) $display("FAIL reset_int_n got %b want 1", bus.int_n); else pass_cnt++;
        total++; if (bus.vec_oe !== 1'b0) $display("FAIL reset_vec_oe got %b want 0", bus.vec_oe); else pass_cnt++;
        total++; if (bus.vec !== 8'h00) $display("FAIL reset_vec got %h want 00", bus.vec); else pass_cnt++;
        total++; if (ieo !== 1'b1) $display("FAIL reset_ieo got %b want 1", ieo); else pass_cnt++;
    endtask

    task automatic test_basic();
        wr_reg(REG_MASK, 8'h00);
        pulse(2);
        total++; if (bus.int_n !== 1'b1) $display("FAIL basic_int_n_n1 got %b want 1", bus.int_n); else pass_cnt++;
        tick();
        total++; if (bus.int_n !== 1'b0) $display("FAIL basic_int_n_n2 got %b want 0", bus.int_n); else pass_cnt++;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h04) $display("FAIL basic_pend got %h want 04", d); else pass_cnt++;
        ack_on();
        total++; if (bus.vec_oe !== 1'b1) $display("FAIL basic_vec_oe got %b want 1", bus.vec_oe); else pass_cnt++;
        total++; if (bus.vec !== 8'h0C) $display("FAIL basic_vec got %h want 0c", bus.vec); else pass_cnt++;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h00) $display("FAIL basic_pend_clr got %h want 00", d); else pass_cnt++;
        ack_off();
        total++; if (bus.vec_oe !== 1'b0) $display("FAIL basic_vec_oe_off got %b want 0", bus.vec_oe); else pass_cnt++;
        total++; if (bus.int_n !== 1'b1) $display("FAIL basic_int_n_after got %b want 1", bus.int_n); else pass_cnt++;
        total++; if (ieo !== 1'b0) $display("FAIL basic_ieo_insv got %b want 0", ieo); else pass_cnt++;
    endtask

    task automatic test_nesting();
        pulse(3);
        tick(); tick();
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h08) $display("FAIL nest_pend3 got %h want 08", d); else pass_cnt++;
        total++; if (bus.int_n !== 1'b1) $display("FAIL nest_blocked got %b want 1", bus.int_n); else pass_cnt++;
        pulse(1);
        tick();
        total++; if (bus.int_n !== 1'b0) $display("FAIL nest_ch1_int got %b want 0", bus.int_n); else pass_cnt++;
        ack_on();
        total++; if (bus.vec !== 8'h0A) $display("FAIL nest_vec got %h want 0a", bus.vec); else pass_cnt++;
        ack_off();
        do_reti();
        tick(); tick();
        total++; if (bus.int_n !== 1'b1) $display("FAIL nest_reti1 got %b want 1", bus.int_n); else pass_cnt++;
        do_reti();
        tick();
        total++; if (bus.int_n !== 1'b0) $display("FAIL nest_reti2 got %b want 0", bus.int_n); else pass_cnt++;
        total++; if (ieo !== 1'b0) $display("FAIL nest_ieo got %b want 0", ieo); else pass_cnt++;
    endtask

    task automatic test_vec_wrap();
        wr_reg(REG_VBASE, 8'hFC);
        ack_on();
        total++; if (bus.vec !== 8'h02) $display("FAIL wrap_vec got %h want 02", bus.vec); else pass_cnt++;
        ack_off();
        do_reti();
        tick();
    endtask

    task automatic test_mode();
        wr_reg(REG_MODE, 8'h01);
        rd_reg(REG_MODE, d);
        total++; if (d !== EXP_MODE) $display("FAIL mode_read got %h want %h", d, EXP_MODE); else pass_cnt++;
        irq[0] = 1'b1;
        tick(); tick();
        total++; if (bus.int_n !== 1'b0) $display("FAIL mode_int got %b want 0", bus.int_n); else pass_cnt++;
        ack_on();
        total++; if (bus.vec !== 8'hFC) $display("FAIL mode_vec got %h want fc", bus.vec); else pass_cnt++;
        ack_off();
        rd_reg(REG_PEND, d);
        total++; if (d !== EXP_LVL_PEND) $display("FAIL mode_pend got %h want %h", d, EXP_LVL_PEND); else pass_cnt++;
        do_reti();
        irq[0] = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.int_n !== 1'b1) $display("FAIL mode_release got %b want 1", bus.int_n); else pass_cnt++;
        wr_reg(REG_MODE, 8'h00);
    endtask

    task automatic test_iei();
        iei = 1'b0;
        pulse(1);
        tick(); tick();
        total++; if (bus.int_n !== 1'b1) $display("FAIL iei_int_n got %b want 1", bus.int_n); else pass_cnt++;
        total++; if (ieo !== 1'b0) $display("FAIL iei_ieo got %b want 0", ieo); else pass_cnt++;
        ack_on();
        total++; if (bus.vec_oe !== 1'b0) $display("FAIL iei_vec_oe got %b want 0", bus.vec_oe); else pass_cnt++;
        ack_off();
        iei = 1'b1;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h02) $display("FAIL iei_pend_kept got %h want 02", d); else pass_cnt++;
        tick(); tick();
        total++; if (bus.int_n !== 1'b0) $display("FAIL iei_resume got %b want 0", bus.int_n); else pass_cnt++;
        ack_on();
        total++; if (bus.vec !== 8'hFE) $display("FAIL iei_vec got %h want fe", bus.vec); else pass_cnt++;
        ack_off();
        do_reti();
        tick();
        total++; if (ieo !== 1'b1) $display("FAIL iei_ieo_idle got %b want 1", ieo); else pass_cnt++;
    endtask

    task automatic test_edge_vs_clear();
        bus.io_cs_n = 1'b0; bus.wr_n = 1'b0; bus.addr = REG_PEND; bus.din = 8'h04;
        irq[2] = 1'b1;
        tick();
        bus.io_cs_n = 1'b1; bus.wr_n = 1'b1;
        irq[2] = 1'b0;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h04) $display("FAIL evc_set_wins got %h want 04", d); else pass_cnt++;
        wr_reg(REG_PEND, 8'h04);
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h00) $display("FAIL evc_w1c got %h want 00", d); else pass_cnt++;
        tick(); tick();
        total++; if (bus.int_n !== 1'b1) $display("FAIL evc_int_n got %b want 1", bus.int_n); else pass_cnt++;
    endtask

    task automatic test_reset_mid_ack();
        pulse(2);
        tick();
        ack_on();
        total++; if (bus.vec_oe !== 1'b1) $display("FAIL rst_ack_oe got %b want 1", bus.vec_oe); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.vec_oe !== 1'b0) $display("FAIL rst_async_oe got %b want 0", bus.vec_oe); else pass_cnt++;
        total++; if (bus.vec !== 8'h00) $display("FAIL rst_async_vec got %h want 00", bus.vec); else pass_cnt++;
        total++; if (bus.int_n !== 1'b1) $display("FAIL rst_async_int_n got %b want 1", bus.int_n); else pass_cnt++;
        rd_reg(REG_MASK, d);
        total++; if (d !== 8'h0F) $display("FAIL rst_async_mask got %h want 0f", d); else pass_cnt++;
        rd_reg(REG_PEND, d);
        total++; if (d !== 8'h00) $display("FAIL rst_async_pend got %h want 00", d); else pass_cnt++;
        rd_reg(REG_VBASE, d);
        total++; if (d !== 8'h08) $display("FAIL rst_async_vbase got %h want 08", d); else pass_cnt++;
        total++; if (ieo !== 1'b1) $display("FAIL rst_async_ieo got %b want 1", ieo); else pass_cnt++;
        ack_off();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_vec_wrap();
        test_mode();
        test_iei();
        test_edge_vs_clear();
        test_reset_mid_ack();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
